// File: rtl/tiletest_lhc_clk_monitor.sv
// LHC clock monitor: synchronises a divided LHC toggle into the sys_clk
// domain and declares lock or loss from edge activity. It also counts
// toggle edges over a fixed power-of-two window so firmware can estimate
// the LHC frequency. It keeps a saturating tally of lock losses.
module tiletest_lhc_clk_monitor #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned LOCK_EDGES  = 16,
  parameter int unsigned WIN_LOG2    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        lhc_toggle,
  output logic        no_lhc_clk,
  output logic [15:0] edge_count,
  output logic        count_valid,
  output logic [7:0]  loss_count
);

  localparam int unsigned GAP_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_EDGES + 1);

  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_EDGES);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Synchroniser, delay stage and pipeline-fill tracker
  logic                sync1_q, sync2_q, dly_q;
  logic [1:0]          fill_q, fill_d;
  logic                edge_s;

  // Gap timer
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                timeout_s;

  // Lock FSM
  state_e              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [7:0]          loss_q, loss_d;

  // Frequency window
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         ecount_q, ecount_d;
  logic                valid_q, valid_d;
  logic                close_s;
  logic [16:0]         sum_s;
  logic [15:0]         sum_sat_s;

  // The edge detector is only trusted once sync2 and the delay stage both
  // hold sampled input, so a reset-time 0 can never look like a toggle.
  always_comb begin
    fill_d = fill_q;
    if (fill_q != 2'd3) begin
      fill_d = fill_q + 2'd1;
    end else begin
      fill_d = fill_q;
    end
  end

  assign edge_s = (sync2_q ^ dly_q) & (fill_q == 2'd3);

  // Two-flop synchroniser for the asynchronous toggle plus the edge delay tap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= lhc_toggle;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      fill_q  <= fill_d;
    end
  end

  // A timeout fires on the TIMEOUT_CYC-th edge-free cycle; an edge always wins.
  assign timeout_s = ~edge_s & (gap_q == GAP_LAST);

  // Gap timer next state: clear on edge, otherwise count up and saturate
  always_comb begin
    gap_d = gap_q;
    if (edge_s) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Lock FSM next state, good-edge count and loss tally
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    loss_d  = loss_q;
    case (state_q)
      ST_LOST: begin
        if (edge_s) begin
          good_d  = GOOD_ONE;
          state_d = (GOOD_LOCK <= GOOD_ONE) ? ST_LOCKED : ST_ACQUIRE;
        end else begin
          state_d = ST_LOST;
        end
      end
      ST_ACQUIRE: begin
        if (edge_s) begin
          good_d = good_q + GOOD_ONE;
          if ((good_q + GOOD_ONE) == GOOD_LOCK) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_ACQUIRE;
          end
        end else if (timeout_s) begin
          good_d  = '0;
          state_d = ST_LOST;
        end else begin
          state_d = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (timeout_s) begin
          good_d  = '0;
          state_d = ST_LOST;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end else begin
            loss_d = loss_q;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        good_d  = '0;
        state_d = ST_LOST;
      end
    endcase
  end

  // Window close happens when the free-running counter is all ones; the
  // edge of that cycle still belongs to the closing window.
  assign close_s   = &win_q;
  assign sum_s     = {1'b0, acc_q} + {16'd0, edge_s};
  assign sum_sat_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];

  // Window counter, accumulator and published edge count next state
  always_comb begin
    win_d    = win_q + WIN_LOG2'(1);
    acc_d    = acc_q;
    ecount_d = ecount_q;
    valid_d  = 1'b0;
    if (close_s) begin
      acc_d    = '0;
      ecount_d = sum_sat_s;
      valid_d  = 1'b1;
    end else begin
      acc_d    = sum_sat_s;
      ecount_d = ecount_q;
      valid_d  = 1'b0;
    end
  end

  // Gap timer, lock FSM and window registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_q    <= '0;
      state_q  <= ST_LOST;
      good_q   <= '0;
      loss_q   <= 8'd0;
      win_q    <= '0;
      acc_q    <= 16'd0;
      ecount_q <= 16'd0;
      valid_q  <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      state_q  <= state_d;
      good_q   <= good_d;
      loss_q   <= loss_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      ecount_q <= ecount_d;
      valid_q  <= valid_d;
    end
  end

  // Lock status is a pure decode of the state register.
  assign no_lhc_clk  = (state_q != ST_LOCKED);
  assign edge_count  = ecount_q;
  assign count_valid = valid_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_tiletest_lhc_clk_monitor.sv
// Bench for tiletest_lhc_clk_monitor: directed scenarios plus random toggle
// traffic, all compared against a cycle-level behavioural model.
module tb_tiletest_lhc_clk_monitor;

  localparam int TIMEOUT = 64;
  localparam int LOCK    = 16;
  localparam int WLOG    = 8;
  localparam int WIN     = 1 << WLOG;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        lhc_toggle;
  logic        no_lhc_clk;
  logic [15:0] edge_count;
  logic        count_valid;
  logic [7:0]  loss_count;

  tiletest_lhc_clk_monitor #(
    .TIMEOUT_CYC (TIMEOUT),
    .LOCK_EDGES  (LOCK),
    .WIN_LOG2    (WLOG)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .lhc_toggle  (lhc_toggle),
    .no_lhc_clk  (no_lhc_clk),
    .edge_count  (edge_count),
    .count_valid (count_valid),
    .loss_count  (loss_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: history of driven toggle values, one per sys_clk edge
  bit hist[$];
  int m_run;        // consecutive good edges since last loss of lock
  int m_loss;
  int m_acc;
  int m_ecount;
  int m_valid;
  int m_last_e;     // clock-edge index of the latest edge pulse
  int m_lock_q;     // clock-edge index at which the model reached lock
  int m_edges;      // edge pulses since reset

  bit tog;
  int prev_nlc;
  int dut_fall_q, dut_rise_q, edges_at_fall;
  bit win_chk;
  bit acq_watch, low_seen;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_run = 0; m_loss = 0; m_acc = 0; m_ecount = 0; m_valid = 0;
    m_last_e = 0; m_lock_q = -1; m_edges = 0;
    prev_nlc = 1;
  endtask

  // One sys_clk cycle: drive toggle, advance model at the edge, compare.
  task automatic step();
    int q;
    bit e, to, was_locked;
    int sum;
    lhc_toggle = tog;
    hist.push_back(tog);
    @(posedge sys_clk);
    q  = hist.size();
    // pulse seen by the logic at edge q reflects the change between the
    // values sampled two and three edges earlier
    e  = (q >= 4) ? (hist[q-3] ^ hist[q-4]) : 1'b0;
    was_locked = (m_run >= LOCK);
    to = !e && ((q - m_last_e) == TIMEOUT);
    if (e) begin
      m_last_e = q;
      m_edges++;
      if (m_run < LOCK) begin
        m_run++;
        if (m_run == LOCK) m_lock_q = q;
      end
    end
    if (to) begin
      if (was_locked && m_loss < 255) m_loss++;
      m_run = 0;
    end
    sum = m_acc + (e ? 1 : 0);
    if (sum > 65535) sum = 65535;
    if ((q % WIN) == 0) begin
      m_ecount = sum; m_acc = 0; m_valid = 1;
    end else begin
      m_acc = sum; m_valid = 0;
    end
    @(negedge sys_clk);
    chk("no_lhc_clk",  no_lhc_clk,  (m_run >= LOCK) ? 0 : 1);
    chk("edge_count",  edge_count,  m_ecount);
    chk("count_valid", count_valid, m_valid);
    chk("loss_count",  loss_count,  m_loss);
    if (win_chk && count_valid) chk("win_edges_64", edge_count, 64);
    if (acq_watch && !no_lhc_clk) low_seen = 1'b1;
    if (prev_nlc == 1 && no_lhc_clk == 1'b0) begin
      dut_fall_q = q; edges_at_fall = m_edges;
    end
    if (prev_nlc == 0 && no_lhc_clk == 1'b1) dut_rise_q = q;
    prev_nlc = no_lhc_clk;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic toggles(input int period, input int count);
    for (int i = 0; i < count; i++) begin
      tog = ~tog;
      step();
      for (int j = 1; j < period; j++) step();
    end
  endtask

  // Asynchronous reset pulse, asserted away from any clock edge.
  task automatic pulse_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async_nlc",  no_lhc_clk,  1);
    chk("rst_async_loss", loss_count,  0);
    chk("rst_async_ecnt", edge_count,  0);
    chk("rst_async_vld",  count_valid, 0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_hold_nlc", no_lhc_clk, 1);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n  = 1'b0;
    tog        = 1'b1;      // held high across release: must not look like an edge
    lhc_toggle = tog;
    win_chk = 1'b0; acq_watch = 1'b0; low_seen = 1'b0;
    dut_fall_q = -1; dut_rise_q = -1; edges_at_fall = -1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_nlc",   no_lhc_clk,  1);
    chk("reset_ecnt",  edge_count,  0);
    chk("reset_loss",  loss_count,  0);
    chk("reset_valid", count_valid, 0);
    sys_rst_n = 1'b1;
    model_reset();
    hold(6);

    // Failed acquisition: 10 edges then silence
    acq_watch = 1'b1;
    toggles(4, 10);
    hold(80);
    acq_watch = 1'b0;
    chk("acq_fail_low_seen", low_seen, 0);
    chk("acq_fail_loss",     loss_count, 0);

    // Lock and steady measurement at one edge per 4 cycles
    toggles(4, 80);
    chk("lock_latency", dut_fall_q - m_lock_q, 0);
    win_chk = 1'b1;
    toggles(4, 150);
    win_chk = 1'b0;

    // Clock loss: state flips on the 64th edge after the last pulse
    hold(70);
    chk("loss_latency", dut_rise_q - m_last_e, 64);
    chk("loss_after_stop", loss_count, 1);

    // 63 edge-free cycles between pulses must not drop lock
    toggles(4, 20);
    tog = ~tog; step();
    hold(63);
    tog = ~tog; step();
    toggles(4, 5);
    chk("gap63_locked", no_lhc_clk, 0);
    chk("gap63_loss",   loss_count, 1);

    // Push loss_count to 3, relock, then reset mid-lock and mid-window
    hold(70);
    toggles(4, 20);
    hold(70);
    toggles(4, 20);
    chk("loss_three", loss_count, 3);
    chk("locked_before_rst", no_lhc_clk, 0);
    hold(37);
    pulse_reset();
    hold(5);
    toggles(4, 20);
    chk("relock_edges", edges_at_fall, 16);
    chk("relock_latency", dut_fall_q - m_lock_q, 0);

    // Random traffic: bursts of toggling at random rates and random silences
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) != 0) toggles($urandom_range(1, 9), $urandom_range(1, 30));
      else                           hold($urandom_range(1, 90));
      if (k == 30) begin
        tog = $urandom_range(0, 1);
        pulse_reset();
        hold(5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
